// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encoding and word geometry for the debug dump sequencer.
package dbg_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/data_mem_dump_ctrl_if.sv
// data_mem_dump_ctrl_if: memory debug read port plus byte stream toward the UART TX.
interface data_mem_dump_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  o_mem_read_en;
  logic [ADDR_WIDTH-1:0] o_debug_addr;
  logic [DATA_WIDTH-1:0] i_debug_data;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  modport master (
    output o_mem_read_en, o_debug_addr, o_tx_data, o_tx_valid,
    input  i_debug_data, i_tx_ready
  );
  modport slave (
    input  o_mem_read_en, o_debug_addr, o_tx_data, o_tx_valid,
    output i_debug_data, i_tx_ready
  );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: holds one word and emits its bytes LSB first over valid/ready.
module word_serializer
  import dbg_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic [8*BYTES_PER_WORD-1:0] i_word,
  input  logic                        i_valid,
  input  logic                        i_ready,
  output logic [7:0]                  o_data,
  output logic                        o_last
);
  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
  logic [1:0]                  idx_q, idx_d;
  logic                        fire;
  always_comb begin
    fire   = i_valid && i_ready;
    word_d = i_load ? i_word : word_q;
    idx_d  = i_load ? 2'd0 : fire ? idx_q + 2'd1 : idx_q;
  end
  assign o_last = fire && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign o_data = i_valid ? word_q[{idx_q, 3'b000} +: 8] : 8'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: rtl/data_mem_dump_ctrl.sv
// data_mem_dump_ctrl: walks a word range of data memory via the debug port and streams it as bytes.
module data_mem_dump_ctrl
  import dbg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CNT_WIDTH  = $clog2(MEM_SIZE / 4) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_word_count,
  data_mem_dump_ctrl_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  load, last, send;
  assign send = state_q == SEND;
  word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (load),
    .i_word  (bus.i_debug_data[DATA_WIDTH-1:0]),
    .i_valid (send),
    .i_ready (bus.i_tx_ready),
    .o_data  (bus.o_tx_data),
    .o_last  (last)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (state_q == IDLE) begin
      if (i_start) begin
        state_d = (i_word_count != '0) ? REQ : DONE;
        addr_d  = (i_word_count != '0) ? (i_base_addr >> WORD_SHIFT) << WORD_SHIFT : addr_q;
        cnt_d   = (i_word_count != '0) ? i_word_count : cnt_q;
      end
    end else if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        REQ:  state_d = WAIT;
        WAIT: begin
          state_d = SEND;
          load    = 1'b1;
        end
        SEND: if (last) begin
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          // explicit wrap keeps non-power-of-two memory sizes correct
          addr_d  = (addr_q == ADDR_WIDTH'(MEM_SIZE - BYTES_PER_WORD)) ? '0
                  : addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
          state_d = (cnt_q == CNT_WIDTH'(1)) ? DONE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.o_mem_read_en = state_q == REQ;
  assign bus.o_debug_addr  = addr_q;
  assign bus.o_tx_valid    = send;
  assign o_busy            = state_q != IDLE;
  assign o_done            = state_q == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
